// File: rtl/cla_nibble_seq.sv
// Wide adder sequencer: streams operand nibbles through an external 4-bit CLA and chains the carry in a register.
// Optional signed-overflow output is enabled by defining CLA_NIBBLE_SEQ_SIGNED_OVF_EN.
`timescale 1ns/1ps
module cla_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic [3:0]             cla_a,
    output logic [3:0]             cla_b,
    output logic                   cla_cin,
    input  logic [3:0]             cla_sum,
    input  logic                   cla_cout
`ifdef CLA_NIBBLE_SEQ_SIGNED_OVF_EN
    ,
    output logic                   overflow
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic          carry_reg, carry_next;
    logic [W-1:0]  a_reg, a_next;
    logic [W-1:0]  b_reg, b_next;
    logic [W-1:0]  result_reg, result_next;
    logic          cout_reg, cout_next;
`ifdef CLA_NIBBLE_SEQ_SIGNED_OVF_EN
    logic          ovf_reg, ovf_next;
`endif

    // Operand nibble views so the CLA mux is a plain array lookup by idx.
    logic [3:0] a_nib [NIBBLES];
    logic [3:0] b_nib [NIBBLES];

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            carry_reg  <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
`ifdef CLA_NIBBLE_SEQ_SIGNED_OVF_EN
            ovf_reg    <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            carry_reg  <= carry_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            result_reg <= result_next;
            cout_reg   <= cout_next;
`ifdef CLA_NIBBLE_SEQ_SIGNED_OVF_EN
            ovf_reg    <= ovf_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        carry_next  = carry_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        result_next = result_reg;
        cout_next   = cout_reg;
`ifdef CLA_NIBBLE_SEQ_SIGNED_OVF_EN
        ovf_next    = ovf_reg;
`endif
        cla_a       = 4'h0;
        cla_b       = 4'h0;
        cla_cin     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next      = a;
                    b_next      = b;
                    idx_next    = '0;
                    carry_next  = cin;
                    result_next = '0;
                    cout_next   = 1'b0;
`ifdef CLA_NIBBLE_SEQ_SIGNED_OVF_EN
                    ovf_next    = 1'b0;
`endif
                    state_next  = RUN;
                end
            end
            RUN: begin
                cla_a      = a_nib[idx_reg];
                cla_b      = b_nib[idx_reg];
                cla_cin    = carry_reg;
                carry_next = cla_cout;
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_reg == IW'(i)) result_next[4*i +: 4] = cla_sum;
                end
                if (idx_reg == LAST) begin
                    state_next = DONE;
                    cout_next  = cla_cout;
`ifdef CLA_NIBBLE_SEQ_SIGNED_OVF_EN
                    // cla_sum[3] of the top nibble is the final sign bit.
                    ovf_next = (a_reg[W-1] == b_reg[W-1]) && (cla_sum[3] != a_reg[W-1]);
`endif
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy   = (state_reg == RUN);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign cout   = cout_reg;
`ifdef CLA_NIBBLE_SEQ_SIGNED_OVF_EN
    assign overflow = ovf_reg;
`endif

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Directed bench for cla_nibble_seq with a behavioural 4-bit CLA and a result scoreboard.
// Overflow checks are compiled in when CLA_NIBBLE_SEQ_SIGNED_OVF_EN is defined.
`timescale 1ns/1ps
module tb_cla_nibble_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] result;
    logic [3:0]   cla_a, cla_b, cla_sum;
    logic         cla_cin, cla_cout;
`ifdef CLA_NIBBLE_SEQ_SIGNED_OVF_EN
    logic         overflow;
`endif

    cla_nibble_seq #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .cla_a    (cla_a),
        .cla_b    (cla_b),
        .cla_cin  (cla_cin),
        .cla_sum  (cla_sum),
        .cla_cout (cla_cout)
`ifdef CLA_NIBBLE_SEQ_SIGNED_OVF_EN
        ,
        .overflow (overflow)
`endif
    );

    // The external narrow adder the sequencer drives.
    assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One add transaction; pulse_at>0 re-pulses start (with junk operands) after that many RUN cycles.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                          input int pulse_at);
        exp_t        e;
        logic [W:0]  full;
        logic [3:0]  na, nb;
        logic [4:0]  t5;
        logic        c;
        int          busy_n;
        bit          seen;
        full = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tcin};
        e.r  = full[W-1:0];
        e.c  = full[W];
        e.o  = (ta[W-1] == tb_v[W-1]) && (full[W-1] != ta[W-1]);
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'b1;
        c = tcin; busy_n = 0; seen = 0;
        for (int cyc = 0; cyc < NIB + 4 && !seen; cyc++) begin
            if (busy) begin
                na = ta[4*busy_n +: 4];
                nb = tb_v[4*busy_n +: 4];
                chk("cla_a", cla_a, na);
                chk("cla_b", cla_b, nb);
                chk("cla_cin", cla_cin, c);
                t5 = {1'b0, na} + {1'b0, nb} + {4'b0, c};
                c = t5[4];
                busy_n++;
                if (busy_n == pulse_at) begin
                    start = 1'b1; a = '1; b = '1;
                end else begin
                    start = 1'b0;
                end
            end else if (done) begin
                seen  = 1;
                start = 1'b0;
                e = sb.pop_front();
                chk("result", result, e.r);
                chk("cout", cout, e.c);
                chk("busy_cycles", busy_n, NIB);
`ifdef CLA_NIBBLE_SEQ_SIGNED_OVF_EN
                chk("overflow", overflow, e.o);
`endif
                $display("op a=%h b=%h cin=%0d -> result=%h cout=%0d", ta, tb_v, tcin, result, cout);
            end
            if (!seen) @(negedge clk);
        end
        chk("done_seen", seen, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cla_a", cla_a, 0);
        chk("result_held", result, e.r);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_cla_cin", cla_cin, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h0003, 16'h000B, 1'b1, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h1234, 16'h4321, 1'b0, 0);
        run_op(16'h0009, 16'h000F, 1'b0, 2);

        // Abort mid-run with an asynchronous reset between edges.
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_cout", cout, 0);
        chk("abort_cla_a", cla_a, 0);
        $display("reset mid-run: busy=%0d done=%0d result=%h cout=%0d", busy, done, result, cout);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        run_op(16'h0001, 16'h0001, 1'b0, 0);

        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
